ddr_request_arbiter: RTL
========================

// Module: ddr_request_arbiter
// PURPOSE
//  Round-robin arbiter sharing one burst-capable DDR memory port between NUM_PORTS requesters
//  (sprite/layer fetch, frame buffer write-back, ROM download). It sits between the requesters
//  and the DDR burst adapter. It grants one requester at a time and holds the grant for a whole
//  burst, until the adapter pulses burstDone. All other requesters are stalled with wait_n low.
// PARAMETERS
//  NUM_PORTS   4   number of requester ports (2..8)
//  ADDR_WIDTH  32  byte address width
//  DATA_WIDTH  64  data width; mask width = DATA_WIDTH/8
// PORTS
//  clock              in   1                   system clock
//  reset              in   1                   synchronous, active-high
//  in_rd              in   NUM_PORTS           per-port read request
//  in_wr              in   NUM_PORTS           per-port write request (one beat per wait_n-high cycle)
//  in_addr            in   NUM_PORTS*ADDR_W    per-port address, port i at [i*ADDR_W +: ADDR_W]
//  in_mask            in   NUM_PORTS*DATA_W/8  per-port byte mask
//  in_din             in   NUM_PORTS*DATA_W    per-port write data
//  in_burstLength     in   NUM_PORTS*8         per-port burst length in words (0 means 1)
//  in_dout            out  DATA_W              read data, broadcast to all ports
//  in_wait_n          out  NUM_PORTS           per-port ready; only owner may be high
//  in_valid           out  NUM_PORTS           per-port read-data valid; owner only
//  in_burstDone       out  NUM_PORTS           per-port end-of-burst pulse; owner only
//  out_rd/out_wr      out  1                   request to DDR adapter
//  out_addr/out_mask  out  ADDR_W / DATA_W/8   muxed from owner
//  out_din            out  DATA_W              muxed from owner
//  out_burstLength    out  8                   muxed from owner
//  out_dout           in   DATA_W              adapter read data
//  out_wait_n         in   1                   adapter ready
//  out_valid          in   1                   adapter read-data valid
//  out_burstDone      in   1                   adapter end-of-burst pulse
//  busy               out  1                   high in GRANT state (debug)
// BEHAVIOUR
//  - FSM states are IDLE and GRANT. Registers are state, owner[$clog2(NUM_PORTS)] and
//    rrPtr[$clog2(NUM_PORTS)]. Reset values are state=IDLE, owner=0, rrPtr=0.
//  - IDLE: req = in_rd|in_wr. If req != 0, owner <= the first set bit searched cyclically from
//    rrPtr upward, and state <= GRANT. Arbitration costs 1 cycle. No downstream request is issued in IDLE.
//  - GRANT: out_rd/out_wr/addr/mask/din/burstLength = owner's inputs. in_wait_n[owner] = out_wait_n,
//    in_valid[owner] = out_valid, in_burstDone[owner] = out_burstDone.
//  - GRANT exit: on out_burstDone, state <= IDLE and rrPtr <= owner+1, wrapping modulo NUM_PORTS.
//    The next grant comes no earlier than 2 cycles after burstDone.
//  - Outputs at reset and in IDLE:
//    - out_rd=out_wr=0; out_addr/mask/din/burstLength = port 0 values (don't-care, but stable).
//    - in_wait_n=0, in_valid=0, in_burstDone=0, busy=0.
//  - Non-owner ports always see wait_n=0, valid=0, burstDone=0. Their requests are held pending
//    and are not dropped.
//  - Owner deasserting rd/wr mid-burst does not release the grant; only out_burstDone releases it.
//  - Read-burst data returns while the owner's rd is low. in_valid is routed by the registered
//    owner, never by the current request.
//  - A request raised in the same cycle as burstDone is considered in the following IDLE cycle.
//    rrPtr is already advanced at that point.
//  - Reset mid-burst: return to IDLE at once and drop the grant. The downstream adapter is reset
//    by the same signal.
//  - Port count not a power of two: owner indices >= NUM_PORTS are unreachable. Pointer wrap uses
//    an explicit compare, not bit truncation.
// STRUCTURE
//  - Shared package ddr_pkg: state enum (IDLE, GRANT), BURST_LEN_WIDTH=8, and the function
//    rr_select(req, ptr) returning the index.
//  - One sub-module, rr_priority_encoder: combinational cyclic first-one search (req, ptr) -> (idx, any).
//  - Muxing and FSM stay in this file.
// TESTING
//  - Single requester: port 1 reads with burstLength=4.
//    -> grant the cycle after request; out_rd=1; 4 in_valid[1] pulses; in_burstDone[1] on beat 4;
//       back to IDLE.
//  - Contention: ports 0,2,3 request reads together with rrPtr=0.
//    -> service order 0,2,3. A second round of requests from 0 and 3 after port 3 is granted
//       is serviced 0 then 3.
//  - Write burst: port 2 writes burstLength=8 while out_wait_n toggles 1,0,1.
//    -> in_wait_n[2] mirrors out_wait_n; other ports' wait_n stay 0; 8 beats reach out_din in order.
//  - Release rule: owner drops rd after the request is accepted; port 0 then requests mid-burst.
//    -> grant held until out_burstDone; port 0 granted exactly 2 cycles after burstDone.
//  - Boundary: burstLength=0 on port 3.
//    -> single beat, burstDone on the first beat; rrPtr wraps to 0.
//  - Reset while port 1 is mid read burst.
//    -> next cycle all outputs at reset values; rrPtr=0; pending port 2 granted 1 cycle after reset release.

Source files
------------

// File: rtl/ddr_pkg.sv
// Shared types and helpers for the DDR request arbiter.
package ddr_pkg;

    localparam int unsigned BURST_LEN_WIDTH = 8;
    localparam int unsigned MAX_PORTS       = 8;
    localparam int unsigned MAX_IDX_WIDTH   = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_e;

    // Cyclic first-one search starting at ptr over the lowest num_ports bits of req.
    // The wrap is an explicit subtract, so indices >= num_ports are never produced.
    function automatic int unsigned rr_select(
        input logic [MAX_PORTS-1:0]     req,
        input logic [MAX_IDX_WIDTH-1:0] ptr,
        input int unsigned              num_ports
    );
        int unsigned idx;
        int unsigned cand;
        logic        found;
        idx   = 0;
        found = 1'b0;
        for (int unsigned i = 0; i < MAX_PORTS; i++) begin
            if (i < num_ports) begin
                cand = 32'(ptr) + i;
                if (cand >= num_ports) begin
                    cand = cand - num_ports;
                end
                if (!found && req[MAX_IDX_WIDTH'(cand)]) begin
                    idx   = cand;
                    found = 1'b1;
                end
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_priority_encoder.sv
// Combinational round-robin search: first requesting port at or after ptr, wrapping.
module rr_priority_encoder
    import ddr_pkg::*;
#(
    parameter int unsigned NUM_PORTS = 4,
    localparam int unsigned IDX_W    = $clog2(NUM_PORTS)
) (
    input  logic [NUM_PORTS-1:0] req,
    input  logic [IDX_W-1:0]     ptr,
    output logic [IDX_W-1:0]     idx_c,
    output logic                 any_c
);

    logic [MAX_PORTS-1:0]     req_wide;
    logic [MAX_IDX_WIDTH-1:0] ptr_wide;

    // Widen to the package search width and pick the winner
    always_comb begin
        req_wide                = '0;
        req_wide[NUM_PORTS-1:0] = req;
        ptr_wide                = MAX_IDX_WIDTH'(ptr);
        idx_c                   = IDX_W'(rr_select(req_wide, ptr_wide, NUM_PORTS));
        any_c                   = |req;
    end

endmodule

// File: rtl/ddr_request_arbiter.sv
// Round-robin arbiter sharing one burst DDR port; grant held from arbitration to burstDone.
module ddr_request_arbiter
    import ddr_pkg::*;
#(
    parameter int unsigned NUM_PORTS  = 4,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 64,
    localparam int unsigned MASK_WIDTH = DATA_WIDTH / 8,
    localparam int unsigned IDX_W      = $clog2(NUM_PORTS)
) (
    input  logic                                 clock,
    input  logic                                 reset,
    // requester side
    input  logic [NUM_PORTS-1:0]                 in_rd,
    input  logic [NUM_PORTS-1:0]                 in_wr,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]      in_addr,
    input  logic [NUM_PORTS*MASK_WIDTH-1:0]      in_mask,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]      in_din,
    input  logic [NUM_PORTS*BURST_LEN_WIDTH-1:0] in_burstLength,
    output logic [DATA_WIDTH-1:0]                in_dout,
    output logic [NUM_PORTS-1:0]                 in_wait_n,
    output logic [NUM_PORTS-1:0]                 in_valid,
    output logic [NUM_PORTS-1:0]                 in_burstDone,
    // adapter side
    output logic                                 out_rd,
    output logic                                 out_wr,
    output logic [ADDR_WIDTH-1:0]                out_addr,
    output logic [MASK_WIDTH-1:0]                out_mask,
    output logic [DATA_WIDTH-1:0]                out_din,
    output logic [BURST_LEN_WIDTH-1:0]           out_burstLength,
    input  logic [DATA_WIDTH-1:0]                out_dout,
    input  logic                                 out_wait_n,
    input  logic                                 out_valid,
    input  logic                                 out_burstDone,
    output logic                                 busy
);

    arb_state_e           state_q, state_d;
    logic [IDX_W-1:0]     owner_q, owner_d;
    logic [IDX_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [NUM_PORTS-1:0] req;
    logic [IDX_W-1:0]     winner_idx_c;
    logic                 req_any_c;
    logic                 granted;
    logic [IDX_W-1:0]     sel;

    assign req = in_rd | in_wr;

    rr_priority_encoder #(
        .NUM_PORTS (NUM_PORTS)
    ) u_rr_priority_encoder (
        .req   (req),
        .ptr   (rr_ptr_q),
        .idx_c (winner_idx_c),
        .any_c (req_any_c)
    );

    // State, owner and round-robin pointer registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Arbitrate in IDLE; release only on the adapter's end-of-burst pulse
    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (req_any_c) begin
                    owner_d = winner_idx_c;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (out_burstDone) begin
                    state_d  = IDLE;
                    rr_ptr_d = (owner_q == IDX_W'(NUM_PORTS - 1)) ? '0 : IDX_W'(owner_q + 1'b1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Route the owner's request downstream and the adapter's handshakes back to the owner only
    always_comb begin
        granted         = (state_q == GRANT);
        sel             = granted ? owner_q : '0;
        out_rd          = granted & in_rd[sel];
        out_wr          = granted & in_wr[sel];
        out_addr        = in_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
        out_mask        = in_mask[sel*MASK_WIDTH +: MASK_WIDTH];
        out_din         = in_din[sel*DATA_WIDTH +: DATA_WIDTH];
        out_burstLength = in_burstLength[sel*BURST_LEN_WIDTH +: BURST_LEN_WIDTH];
        in_dout         = out_dout;
        in_wait_n       = '0;
        in_valid        = '0;
        in_burstDone    = '0;
        if (granted) begin
            in_wait_n[owner_q]    = out_wait_n;
            in_valid[owner_q]     = out_valid;
            in_burstDone[owner_q] = out_burstDone;
        end
        busy = granted;
    end

endmodule
